scan_sequencer: RTL

SCAN_SEQUENCER -- requirements
Module: scan_sequencer

---
 rtl/scan_sequencer_pkg.sv | 14 +
 rtl/scan_sequencer_if.sv | 29 ++
 rtl/scan_sel_counter.sv | 36 +++
 rtl/scan_sequencer.sv | 100 ++++++++++
 4 files changed

// File: rtl/scan_sequencer_pkg.sv
// Shared types and constants for the scan sequencer slice.
package scan_sequencer_pkg;

  localparam int N_BITS = 8;
  localparam int SEL_W  = 3;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_EMIT
  } scan_state_t;

endpackage

// File: rtl/scan_sequencer_if.sv
// Word-in / mux-loop / serial-out signal bundle for scan_sequencer.
interface scan_sequencer_if;
  import scan_sequencer_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [N_BITS-1:0] in_data;
  logic              rev;
  logic [N_BITS-1:0] mux_data;
  logic [SEL_W-1:0]  mux_sel;
  logic              mux_out;
  logic              ser_bit;
  logic              ser_valid;
  logic              ser_last;
  logic              ser_ready;
  logic              done;

  // slave: the sequencer itself; master: the surrounding environment
  modport slave (
    input  in_valid, in_data, rev, mux_out, ser_ready,
    output in_ready, mux_data, mux_sel, ser_bit, ser_valid, ser_last, done
  );

  modport master (
    output in_valid, in_data, rev, mux_out, ser_ready,
    input  in_ready, mux_data, mux_sel, ser_bit, ser_valid, ser_last, done
  );

endinterface

// File: rtl/scan_sel_counter.sv
// 3-bit mux select counter: loads 0 or 7 by direction, steps toward the far end, flags it.
module scan_sel_counter
  import scan_sequencer_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             down_in,
  input  logic             step,
  output logic [SEL_W-1:0] sel,
  output logic             term
);

  logic [SEL_W-1:0] sel_q;
  logic             down_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel_q  <= '0;
      down_q <= 1'b0;
    end else if (load) begin
      sel_q  <= down_in ? '1 : '0;
      down_q <= down_in;
    end else if (step && !term) begin
      // never steps past the terminal index, so no wrap within a word
      sel_q <= down_q ? sel_q - 1'b1 : sel_q + 1'b1;
    end
  end

  always_comb begin
    term = down_q ? (sel_q == '0) : (sel_q == '1);
  end

  assign sel = sel_q;

endmodule

// File: rtl/scan_sequencer.sv
// Serialises an 8-bit word through an external 8:1 mux, with optional settle time per select.
module scan_sequencer
  import scan_sequencer_pkg::*;
#(
  parameter int unsigned SETTLE = 0
) (
  input  logic            clk,
  input  logic            reset,
  scan_sequencer_if.slave bus
);

  localparam bit               HAS_SETTLE  = (SETTLE > 0);
  localparam logic [CNT_W-1:0] SETTLE_LAST = HAS_SETTLE ? CNT_W'(SETTLE - 1) : '0;

  scan_state_t       state, state_nxt;
  logic [N_BITS-1:0] data_q;
  logic [CNT_W-1:0]  settle_cnt;
  logic              done_q;
  logic [SEL_W-1:0]  sel;
  logic              sel_term;
  logic              accept, hs, last_hs;
  logic              in_ready_c, ser_valid_c, ser_last_c, ser_bit_c;

  assign accept  = (state == ST_IDLE) && bus.in_valid;
  assign hs      = (state == ST_EMIT) && bus.ser_ready;
  assign last_hs = hs && sel_term;

  scan_sel_counter u_sel (
    .clk     (clk),
    .reset   (reset),
    .load    (accept),
    .down_in (bus.rev),
    .step    (hs),
    .sel     (sel),
    .term    (sel_term)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      data_q     <= '0;
      settle_cnt <= '0;
      done_q     <= 1'b0;
    end else begin
      state  <= state_nxt;
      done_q <= last_hs;
      if (accept) begin
        data_q <= bus.in_data;
      end
      if (state == ST_SETTLE && settle_cnt != SETTLE_LAST) begin
        settle_cnt <= settle_cnt + 1'b1;
      end else begin
        settle_cnt <= '0;
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    in_ready_c  = 1'b0;
    ser_valid_c = 1'b0;
    ser_last_c  = 1'b0;
    ser_bit_c   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) begin
          state_nxt = HAS_SETTLE ? ST_SETTLE : ST_EMIT;
        end
      end
      ST_SETTLE: begin
        if (settle_cnt == SETTLE_LAST) begin
          state_nxt = ST_EMIT;
        end
      end
      ST_EMIT: begin
        ser_valid_c = 1'b1;
        ser_last_c  = sel_term;
        ser_bit_c   = bus.mux_out;
        if (bus.ser_ready) begin
          if (sel_term) begin
            state_nxt = ST_IDLE;
          end else begin
            state_nxt = HAS_SETTLE ? ST_SETTLE : ST_EMIT;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.ser_valid = ser_valid_c;
  assign bus.ser_last  = ser_last_c;
  assign bus.ser_bit   = ser_bit_c;
  assign bus.mux_data  = data_q;
  assign bus.mux_sel   = sel;
  assign bus.done      = done_q;

endmodule
